fact_mmio_responder: RTL and testbench

- Device-side end of the SoC memory-mapped bus: a factorial accelerator slave that answers the per-device we/addr/wdata/rdata port set the memory map drives.
- Holds a small register file: control, operand N, status, result.
- Runs an iterative multiply FSM and raises a done interrupt towards the interrupt controller.
- Four instances sit behind the memory map as factorial units 0-3.

---
 rtl/fact_mmio_responder_if.sv | 16 +
 rtl/fact_mmio_responder.sv | 156 +++++++++++++++
 tb/tb_fact_mmio_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fact_mmio_responder_if.sv
// Per-device memory-mapped port set between the address decoder (master) and
// one factorial unit (slave).
interface fact_mmio_responder_if #(
  parameter int DATA_W = 32
);
  // No valid/ready: we is already address-qualified and takes effect on the
  // clk edge where it is high; rdata is combinational from addr in every cycle.
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  modport master (output we, output addr, output wdata, input rdata, input irq);
  modport slave  (input we, input addr, input wdata, output rdata, output irq);
endinterface

// File: rtl/fact_mmio_responder.sv
// Factorial accelerator slave: CTRL/N/STATUS/RESULT registers and an iterative
// multiply FSM. Define FACT_IRQ_EN to implement the IE bit and the done interrupt.
module fact_mmio_responder #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fact_mmio_responder_if.slave  bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MULT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);
  localparam logic [N_W-1:0] ONE_N   = N_W'(1);

  state_t            r_state;
  logic [N_W-1:0]    r_n;
  logic [N_W-1:0]    r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic              r_err;

  logic [1:0]        w_sel;
  logic              w_wr_ctrl;
  logic              w_wr_n;
  logic              w_go;
  logic              w_clr;
  logic              w_busy;
  logic              w_n_err;
  logic              w_n_triv;
  logic              w_last;
  logic              w_done_nxt;
  logic              w_ie;
  logic [DATA_W-1:0] w_cnt_ext;
  logic              w_unused;

  assign w_sel     = bus.addr[3:2];
  assign w_wr_ctrl = bus.we & (w_sel == 2'd0);
  assign w_wr_n    = bus.we & (w_sel == 2'd1);
  assign w_go      = w_wr_ctrl & bus.wdata[0];
  assign w_clr     = w_wr_ctrl & bus.wdata[1];
  assign w_busy    = (r_state == S_LOAD) | (r_state == S_MULT);
  assign w_n_err   = r_n > MAX_N_V;
  assign w_n_triv  = r_n <= ONE_N;
  assign w_last    = r_cnt == ONE_N;
  assign w_cnt_ext = {{(DATA_W-N_W){1'b0}}, r_cnt};
  assign w_unused  = &{1'b0, bus.addr[31:4], bus.addr[1:0], bus.wdata};

  assign o_dbg_state = r_state;

  // DONE's next value is shared with the interrupt register so irq rises and
  // falls on exactly the same edge as DONE.
  always_comb begin
    w_done_nxt = r_done;
    case (r_state)
      S_IDLE, S_DONE: if (w_go || w_clr) w_done_nxt = 1'b0;
      S_LOAD:         if (w_n_err || w_n_triv) w_done_nxt = 1'b1;
      S_MULT:         if (w_last) w_done_nxt = 1'b1;
      default:        w_done_nxt = r_done;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_wr_n && !w_busy) r_n <= bus.wdata[N_W-1:0];
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_go) begin
            r_err   <= 1'b0;
            r_state <= S_LOAD;
          end else if (w_clr) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (w_n_err) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_n_triv) begin
            r_result <= {{(DATA_W-1){1'b0}}, 1'b1};
            r_state  <= S_DONE;
          end else begin
            r_acc   <= {{(DATA_W-N_W){1'b0}}, r_n};
            r_cnt   <= r_n - ONE_N;
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          // The last multiply (by 2) happened on the previous edge; publish it.
          if (w_last) begin
            r_result <= r_acc;
            r_state  <= S_DONE;
          end else begin
            r_acc <= r_acc * w_cnt_ext;
            r_cnt <= r_cnt - ONE_N;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FACT_IRQ_EN
  logic r_ie;
  logic r_irq;
  logic w_ie_nxt;

  assign w_ie_nxt = w_wr_ctrl ? bus.wdata[2] : r_ie;
  assign w_ie     = r_ie;
  assign bus.irq  = r_irq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ie  <= w_ie_nxt;
      r_irq <= w_done_nxt & w_ie_nxt;
    end
  end
`else
  assign w_ie    = 1'b0;
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    bus.rdata = '0;
    case (w_sel)
      2'd0:    bus.rdata = {{(DATA_W-3){1'b0}}, w_ie, 2'b00};
      2'd1:    bus.rdata = {{(DATA_W-N_W){1'b0}}, r_n};
      2'd2:    bus.rdata = {{(DATA_W-3){1'b0}}, w_busy, r_err, r_done};
      default: bus.rdata = r_result;
    endcase
  end

endmodule

// File: tb/tb_fact_mmio_responder.sv
// Self-checking bench for fact_mmio_responder: table of operands with expected
// latency/status/result, plus hand-written reset, busy and interrupt sequences.
module tb_fact_mmio_responder;

  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_N    = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_RES  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  fact_mmio_responder_if #(.DATA_W(32)) bus ();

  fact_mmio_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_reg(input logic [1:0] off, input logic [31:0] d);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.addr  = {28'd0, off, 2'b00};
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic read_reg(input logic [1:0] off, output logic [31:0] d);
    bus.addr = {28'd0, off, 2'b00};
    #1;
    d = bus.rdata;
  endtask

  // Counts edges until STATUS.DONE is seen; also reports irq seen before DONE.
  task automatic wait_done(input int max_cyc, output int cyc, output logic [31:0] st,
                           output logic irq_early);
    cyc       = 0;
    st        = '0;
    irq_early = 1'b0;
    while (cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      read_reg(OFF_STAT, st);
      if (st[0]) break;
      if (bus.irq) irq_early = 1'b1;
    end
  endtask

  task automatic pop_and_check(input string nm);
    logic [31:0] r;
    logic [31:0] e;
    read_reg(OFF_RES, r);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%08h", nm, r);
    end else begin
      e = exp_q.pop_front();
      chk(nm, r, e);
    end
  endtask

  typedef struct {
    logic [3:0]  n;
    int          lat;
    logic [31:0] st;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] d;
    logic [31:0] st;
    int          cyc;
    logic        irq_early;

    vecs[0] = '{n: 4'd0,  lat: 1,  st: 32'h1, res: 32'd1};
    vecs[1] = '{n: 4'd1,  lat: 1,  st: 32'h1, res: 32'd1};
    vecs[2] = '{n: 4'd2,  lat: 2,  st: 32'h1, res: 32'd2};
    vecs[3] = '{n: 4'd5,  lat: 5,  st: 32'h1, res: 32'd120};
    vecs[4] = '{n: 4'd7,  lat: 7,  st: 32'h1, res: 32'd5040};
    vecs[5] = '{n: 4'd12, lat: 12, st: 32'h1, res: 32'h1C8CFC00};
    vecs[6] = '{n: 4'd13, lat: 1,  st: 32'h3, res: 32'd0};
    vecs[7] = '{n: 4'd15, lat: 1,  st: 32'h3, res: 32'd0};

    rst_n     = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset with a GO write held across reset edges: reset must win.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.we    = 1'b1;
    bus.addr  = 32'h0;
    bus.wdata = 32'h7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.we    = 1'b0;
    bus.wdata = '0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    read_reg(OFF_CTRL, d); chk("reset_ctrl", d, 32'h0);
    read_reg(OFF_N, d);    chk("reset_n", d, 32'h0);
    read_reg(OFF_STAT, d); chk("reset_status", d, 32'h0);
    read_reg(OFF_RES, d);  chk("reset_result", d, 32'h0);
    chk("reset_state", {30'd0, dbg_state}, 32'h0);
    chk("reset_irq", {31'd0, bus.irq}, 32'h0);

    // Table-driven operands.
    for (int i = 0; i < 8; i++) begin
      write_reg(OFF_N, {28'd0, vecs[i].n});
      read_reg(OFF_N, d);
      chk($sformatf("n_readback[%0d]", vecs[i].n), d, {28'd0, vecs[i].n});
      write_reg(OFF_CTRL, 32'h1);
      exp_q.push_back(vecs[i].res);
      read_reg(OFF_STAT, d);
      chk($sformatf("busy_after_go[%0d]", vecs[i].n), d, 32'h4);
      chk($sformatf("state_load[%0d]", vecs[i].n), {30'd0, dbg_state}, 32'h1);
      wait_done(40, cyc, st, irq_early);
      chk($sformatf("latency[%0d]", vecs[i].n), cyc, vecs[i].lat);
      chk($sformatf("status[%0d]", vecs[i].n), st, vecs[i].st);
      pop_and_check($sformatf("result[%0d]", vecs[i].n));
    end

    // After the N=15 error run, CLR returns to a clean IDLE.
    write_reg(OFF_CTRL, 32'h2);
    read_reg(OFF_STAT, d);
    chk("clr_status", d, 32'h0);
    chk("clr_state", {30'd0, dbg_state}, 32'h0);
    read_reg(OFF_RES, d);
    chk("clr_keeps_result", d, 32'h0);

    // GO and CLR together from DONE: GO wins.
    write_reg(OFF_N, 32'd3);
    write_reg(OFF_CTRL, 32'h1);
    wait_done(40, cyc, st, irq_early);
    chk("n3_latency", cyc, 3);
    write_reg(OFF_CTRL, 32'h3);
    exp_q.push_back(32'd6);
    read_reg(OFF_STAT, d);
    chk("go_clr_busy", d, 32'h4);
    wait_done(40, cyc, st, irq_early);
    chk("go_clr_latency", cyc, 3);
    pop_and_check("go_clr_result");

    // Writes to N, GO and CLR while busy are all ignored.
    write_reg(OFF_N, 32'd6);
    write_reg(OFF_CTRL, 32'h1);
    exp_q.push_back(32'd720);
    write_reg(OFF_N, 32'd3);
    write_reg(OFF_CTRL, 32'h1);
    write_reg(OFF_CTRL, 32'h2);
    read_reg(OFF_RES, d);
    chk("result_held_busy", d, 32'd6);
    wait_done(40, cyc, st, irq_early);
    chk("busy_ignore_latency", cyc + 3, 6);
    chk("busy_ignore_status", st, 32'h1);
    pop_and_check("busy_ignore_result");
    read_reg(OFF_N, d);
    chk("busy_ignore_n", d, 32'd6);

    // Reset in the middle of a run.
    write_reg(OFF_CTRL, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(OFF_N, d);    chk("midrst_n", d, 32'h0);
    read_reg(OFF_STAT, d); chk("midrst_status", d, 32'h0);
    read_reg(OFF_RES, d);  chk("midrst_result", d, 32'h0);
    chk("midrst_state", {30'd0, dbg_state}, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    read_reg(OFF_STAT, d); chk("midrst_no_done", d, 32'h0);
    chk("midrst_irq", {31'd0, bus.irq}, 32'h0);

`ifdef FACT_IRQ_EN
    write_reg(OFF_CTRL, 32'h4);
    read_reg(OFF_CTRL, d);
    chk("ie_readback", d, 32'h4);
    write_reg(OFF_N, 32'd4);
    write_reg(OFF_CTRL, 32'h5);
    exp_q.push_back(32'd24);
    wait_done(40, cyc, st, irq_early);
    chk("irq_latency", cyc, 4);
    chk("irq_not_early", {31'd0, irq_early}, 32'h0);
    chk("irq_with_done", {31'd0, bus.irq}, 32'h1);
    pop_and_check("irq_result");
    write_reg(OFF_CTRL, 32'h6);
    chk("irq_cleared", {31'd0, bus.irq}, 32'h0);
    read_reg(OFF_STAT, d);
    chk("irq_clr_status", d, 32'h0);
`else
    write_reg(OFF_CTRL, 32'h4);
    read_reg(OFF_CTRL, d);
    chk("ie_not_impl", d, 32'h0);
    write_reg(OFF_N, 32'd4);
    write_reg(OFF_CTRL, 32'h5);
    exp_q.push_back(32'd24);
    wait_done(40, cyc, st, irq_early);
    chk("noirq_latency", cyc, 4);
    chk("noirq_not_early", {31'd0, irq_early}, 32'h0);
    chk("noirq_at_done", {31'd0, bus.irq}, 32'h0);
    pop_and_check("noirq_result");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
